// File: rtl/extend_pkg.sv
// Shared types for the immediate extender: extension modes and buffer occupancy.
package extend_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      SIGN      = 3'd0,
      ZERO      = 3'd1,
      UPPER     = 3'd2,
      SIGN_SHL2 = 3'd3,
      SIGN_BYTE = 3'd4,
      ZERO_BYTE = 3'd5,
      RSVD6     = 3'd6,
      RSVD7     = 3'd7
   } mode_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

endpackage

// File: rtl/extend_core.sv
// Combinational immediate extension: (imm, mode) -> (result, err); zero latency, no flow control.
// Reserved modes yield an all-zero result with err set.
module extend_core
   import extend_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
) (
   input  logic [IN_WIDTH-1:0]  i_imm,
   input  logic [MODE_W-1:0]    i_mode,
   output logic [OUT_WIDTH-1:0] o_result,
   output logic                 o_err
);

   localparam int E = OUT_WIDTH - IN_WIDTH;

   logic [OUT_WIDTH-1:0] w_sext;
   logic [OUT_WIDTH-1:0] w_zext;
   logic [OUT_WIDTH-1:0] w_sbyte;
   logic [OUT_WIDTH-1:0] w_zbyte;

   assign w_sext  = OUT_WIDTH'($signed(i_imm));
   assign w_zext  = OUT_WIDTH'(i_imm);
   assign w_sbyte = OUT_WIDTH'($signed(i_imm[7:0]));
   assign w_zbyte = OUT_WIDTH'(i_imm[7:0]);

   always_comb begin
      o_result = '0;
      o_err    = 1'b0;
      case (mode_t'(i_mode))
         SIGN:      o_result = w_sext;
         ZERO:      o_result = w_zext;
         UPPER:     o_result = w_zext << E;
         SIGN_SHL2: o_result = w_sext << 2;
         SIGN_BYTE: o_result = w_sbyte;
         ZERO_BYTE: o_result = w_zbyte;
         default:   o_err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/extend_unit.sv
// Immediate extender with a 2-entry output buffer; result visible one cycle after push.
// IN_READY drops only when both entries are held and depends on registered state alone.
module extend_unit
   import extend_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [IN_WIDTH-1:0]  IN,
   input  logic [MODE_W-1:0]    MODE,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [OUT_WIDTH-1:0] OUT,
   output logic                 OUT_ERR
);

   localparam int ENT_W = OUT_WIDTH + 1;

   occ_t              r_occ;
   logic [ENT_W-1:0]  r_head;
   logic [ENT_W-1:0]  r_tail;

   logic [OUT_WIDTH-1:0] w_result;
   logic                 w_err;
   logic [ENT_W-1:0]     w_entry;
   logic                 w_push;
   logic                 w_pop;

   extend_core #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_core (
      .i_imm    (IN),
      .i_mode   (MODE),
      .o_result (w_result),
      .o_err    (w_err)
   );

   assign w_entry   = {w_err, w_result};
   assign IN_READY  = (r_occ != FULL);
   assign OUT_VALID = (r_occ != EMPTY);
   assign w_push    = IN_VALID && IN_READY;
   assign w_pop     = OUT_VALID && OUT_READY;

   // Head register always drives the output; gate it so an idle port reads zero.
   assign OUT     = OUT_VALID ? r_head[OUT_WIDTH-1:0] : '0;
   assign OUT_ERR = OUT_VALID & r_head[OUT_WIDTH];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_occ  <= EMPTY;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case (r_occ)
            EMPTY: begin
               if (w_push) begin
                  r_head <= w_entry;
                  r_occ  <= ONE;
               end
            end
            ONE: begin
               if (w_push && w_pop) begin
                  r_head <= w_entry;
               end else if (w_push) begin
                  r_tail <= w_entry;
                  r_occ  <= FULL;
               end else if (w_pop) begin
                  r_occ  <= EMPTY;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_head <= r_tail;
                  r_occ  <= ONE;
               end
            end
            default: r_occ <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_extend_unit.sv
// Directed scenarios plus randomized traffic checked against an arithmetic reference model.
module tb_extend_unit;

   logic        CLK;
   logic        RESET_N;
   logic        IN_VALID;
   logic        IN_READY;
   logic [15:0] IN;
   logic [2:0]  MODE;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT;
   logic        OUT_ERR;

   int n_vec = 0;
   int n_err = 0;

   extend_unit #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN        (IN),
      .MODE      (MODE),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT       (OUT),
      .OUT_ERR   (OUT_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam logic [15:0] SW_IN  [8] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001,
                                          16'h8001, 16'h1280, 16'h1280, 16'h8001};
   localparam logic [2:0]  SW_MD  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5};
   localparam logic [31:0] SW_EXP [8] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004,
                                          32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'h00000001};

   // Returns {err, result} computed from plain integer arithmetic.
   function automatic logic [32:0] ref_ext(input int unsigned imm, input int unsigned mode);
      longint s, b, r;
      s = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
      b = longint'(imm % 256);
      case (mode)
         0: r = s;
         1: r = longint'(imm);
         2: r = longint'(imm) * 65536;
         3: r = s * 4;
         4: r = (b >= 128) ? b - 256 : b;
         5: r = b;
         default: return {1'b1, 32'h0};
      endcase
      return {1'b0, r[31:0]};
   endfunction

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
      n_vec++; if (OUT !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h want 00000000", OUT); end
      n_vec++; if (OUT_ERR !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %b want 0", OUT_ERR); end
      n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
   endtask

   task automatic test_mode_sweep;
      OUT_READY = 1'b1;
      for (int k = 0; k < 8; k++) begin
         IN_VALID = 1'b1; IN = SW_IN[k]; MODE = SW_MD[k];
         tick();
         n_vec++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL sweep_valid[%0d]: got %b want 1", k, OUT_VALID); end
         n_vec++; if (OUT !== SW_EXP[k]) begin n_err++; $display("FAIL sweep_out[%0d]: got %h want %h", k, OUT, SW_EXP[k]); end
         n_vec++; if (OUT_ERR !== 1'b0) begin n_err++; $display("FAIL sweep_err[%0d]: got %b want 0", k, OUT_ERR); end
      end
      IN_VALID = 1'b0;
      tick();
      n_vec++; if (OUT_VALID !== 1'b0 || OUT !== 32'h0) begin n_err++; $display("FAIL sweep_drain: got valid=%b out=%h want 0/0", OUT_VALID, OUT); end
   endtask

   task automatic test_reserved;
      OUT_READY = 1'b1;
      IN_VALID = 1'b1; IN = 16'hFFFF; MODE = 3'd6;
      tick();
      n_vec++; if (OUT !== 32'h0 || OUT_ERR !== 1'b1 || OUT_VALID !== 1'b1) begin n_err++; $display("FAIL rsvd6: got v=%b out=%h err=%b want 1/00000000/1", OUT_VALID, OUT, OUT_ERR); end
      IN = 16'h1234; MODE = 3'd0;
      tick();
      n_vec++; if (OUT !== 32'h00001234 || OUT_ERR !== 1'b0) begin n_err++; $display("FAIL rsvd_follow: got out=%h err=%b want 00001234/0", OUT, OUT_ERR); end
      IN = 16'h0042; MODE = 3'd7;
      tick();
      n_vec++; if (OUT !== 32'h0 || OUT_ERR !== 1'b1) begin n_err++; $display("FAIL rsvd7: got out=%h err=%b want 00000000/1", OUT, OUT_ERR); end
      IN_VALID = 1'b0;
      tick();
      n_vec++; if (OUT_VALID !== 1'b0 || OUT_ERR !== 1'b0) begin n_err++; $display("FAIL rsvd_drain: got v=%b err=%b want 0/0", OUT_VALID, OUT_ERR); end
   endtask

   task automatic test_backpressure;
      OUT_READY = 1'b0;
      IN_VALID = 1'b1; IN = 16'h0001; MODE = 3'd0;
      tick();
      n_vec++; if (IN_READY !== 1'b1 || OUT !== 32'h1) begin n_err++; $display("FAIL bp_a: got rdy=%b out=%h want 1/00000001", IN_READY, OUT); end
      IN = 16'h0002;
      tick();
      n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_full_rdy: got %b want 0", IN_READY); end
      IN = 16'h0003;
      tick();
      n_vec++; if (IN_READY !== 1'b0 || OUT !== 32'h1 || OUT_VALID !== 1'b1) begin n_err++; $display("FAIL bp_hold: got rdy=%b v=%b out=%h want 0/1/00000001", IN_READY, OUT_VALID, OUT); end
      OUT_READY = 1'b1;
      tick();
      n_vec++; if (OUT !== 32'h2 || IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_b: got out=%h rdy=%b want 00000002/1", OUT, IN_READY); end
      tick();
      n_vec++; if (OUT !== 32'h3 || OUT_VALID !== 1'b1) begin n_err++; $display("FAIL bp_c: got v=%b out=%h want 1/00000003", OUT_VALID, OUT); end
      IN_VALID = 1'b0;
      tick();
      n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got valid=%b out=%h want 0", OUT_VALID, OUT); end
   endtask

   task automatic test_back_to_back;
      OUT_READY = 1'b1;
      IN_VALID = 1'b1; MODE = 3'd0; IN = 16'h0000;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_vec++; if (OUT_VALID !== 1'b1 || OUT !== 32'(k) || IN_READY !== 1'b1) begin n_err++; $display("FAIL stream[%0d]: got v=%b out=%h rdy=%b want 1/%h/1", k, OUT_VALID, OUT, IN_READY, 32'(k)); end
         if (k < 7) IN = 16'(k + 1);
         else IN_VALID = 1'b0;
      end
      tick();
      n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL stream_end: got %b want 0", OUT_VALID); end
   endtask

   task automatic test_random;
      logic [32:0] q[$];
      logic [32:0] got;
      for (int c = 0; c < 400; c++) begin
         IN_VALID  = ($urandom_range(0, 9) < 7);
         OUT_READY = ($urandom_range(0, 9) < (c < 360 ? 5 : 10));
         if (c >= 360) IN_VALID = 1'b0;
         IN   = 16'($urandom);
         MODE = 3'($urandom_range(0, 7));
         @(negedge CLK);
         n_vec++; if (OUT_VALID !== (q.size() > 0) || IN_READY !== (q.size() < 2)) begin n_err++; $display("FAIL rand_occ[%0d]: got v=%b rdy=%b want occupancy %0d", c, OUT_VALID, IN_READY, q.size()); end
         got = {OUT_ERR, OUT};
         if (q.size() > 0) begin
            n_vec++; if (got !== q[0]) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", c, got, q[0]); end
         end else begin
            n_vec++; if (got !== 33'h0) begin n_err++; $display("FAIL rand_idle[%0d]: got %h want 0", c, got); end
         end
         if (OUT_VALID && OUT_READY && q.size() > 0) void'(q.pop_front());
         if (IN_VALID && IN_READY) q.push_back(ref_ext(int'(IN), int'(MODE)));
         tick();
      end
      IN_VALID = 1'b0;
      n_vec++; if (q.size() != 0 || OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rand_leftover: got %0d queued v=%b want 0/0", q.size(), OUT_VALID); end
   endtask

   task automatic test_reset_mid;
      OUT_READY = 1'b0;
      IN_VALID = 1'b1; MODE = 3'd1; IN = 16'hAAAA;
      tick();
      IN = 16'hBBBB;
      tick();
      IN_VALID = 1'b0;
      n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rstmid_full: got rdy=%b want 0", IN_READY); end
      #2 RESET_N = 1'b0;
      #1;
      n_vec++; if (OUT_VALID !== 1'b0 || OUT !== 32'h0 || OUT_ERR !== 1'b0 || IN_READY !== 1'b1) begin n_err++; $display("FAIL rstmid_async: got v=%b out=%h err=%b rdy=%b want 0/0/0/1", OUT_VALID, OUT, OUT_ERR, IN_READY); end
      #3 RESET_N = 1'b1;
      tick();
      n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_discard: got v=%b want 0", OUT_VALID); end
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN = 16'h0055; MODE = 3'd1;
      tick();
      n_vec++; if (OUT_VALID !== 1'b1 || OUT !== 32'h55) begin n_err++; $display("FAIL rstmid_first: got v=%b out=%h want 1/00000055", OUT_VALID, OUT); end
      IN_VALID = 1'b0;
      tick();
   endtask

   initial begin
      RESET_N = 1'b0; IN_VALID = 1'b0; IN = '0; MODE = '0; OUT_READY = 1'b0;
      #2;
      test_reset();
      #10 RESET_N = 1'b1;
      tick();
      test_mode_sweep();
      test_reserved();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
